// File: rtl/ysyx_22050612_pkg.sv
// Shared types and constants for the ysyx_22050612 instruction fetch path.
package ysyx_22050612_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [63:0] FETCH_RESET_PC = 64'h8000_0000;
  localparam int unsigned FETCH_INST_W   = 32;
  localparam logic [63:0] PC_STEP        = 64'd4;

endpackage

// File: rtl/ysyx_22050612_fetch_pc.sv
// Architectural PC, pending redirect target and kill flag with next-PC select.
module ysyx_22050612_fetch_pc
  import ysyx_22050612_pkg::*;
#(
  parameter logic [63:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  fetch_state_e state_i,
  input  logic         redirect_valid_i,
  input  logic [63:0]  redirect_pc_i,
  input  logic         rsp_valid_i,
  input  logic         inst_ready_i,
  output logic [63:0]  pc_o,
  output logic         kill_o
);

  logic [63:0] pc_q, pc_d;
  logic [63:0] pending_q, pending_d;
  logic        kill_q, kill_d;
  logic [63:0] target;

  assign target = redirect_pc_i & ~64'h3;

  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    kill_d    = kill_q;
    case (state_i)
      ST_IDLE: begin
        if (redirect_valid_i) pc_d = target;
      end
      // The request address must not move while it is on the bus, so park the target.
      ST_REQ: begin
        if (redirect_valid_i) begin
          pending_d = target;
          kill_d    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rsp_valid_i) begin
          kill_d = 1'b0;
          if (redirect_valid_i) pc_d = target;
          else if (kill_q)      pc_d = pending_q;
        end else if (redirect_valid_i) begin
          pending_d = target;
          kill_d    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid_i)  pc_d = target;
        else if (inst_ready_i) pc_d = pc_q + PC_STEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pending_q <= 64'd0;
      kill_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      kill_q    <= kill_d;
    end
  end

  assign pc_o   = pc_q;
  assign kill_o = kill_q;

endmodule

// File: rtl/ysyx_22050612_fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for response, hold for decode.
//   state | meaning
//   IDLE  | first cycle after reset release
//   REQ   | request for pc on the imem request channel
//   WAIT  | request accepted, waiting for the response (may be killed)
//   HOLD  | instruction presented to decode
module ysyx_22050612_fetch_unit
  import ysyx_22050612_pkg::*;
#(
  parameter logic [63:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned INST_W   = FETCH_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [63:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output logic [63:0]       fetch_cnt
);

  fetch_state_e      state_q;
  logic              req_valid_q;
  logic              inst_valid_q;
  logic [INST_W-1:0] inst_q;
  logic [63:0]       inst_pc_q;
  logic [63:0]       cnt_q;
  logic [63:0]       pc;
  logic              kill;

  ysyx_22050612_fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk              (clk),
    .rst              (rst),
    .state_i          (state_q),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .rsp_valid_i      (imem_rsp_valid),
    .inst_ready_i     (inst_ready),
    .pc_o             (pc),
    .kill_o           (kill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      cnt_q        <= 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_REQ;
          req_valid_q <= 1'b1;
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            state_q     <= ST_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            // Wrong-path data is dropped here and never reaches decode.
            if (redirect_valid || kill) begin
              state_q     <= ST_REQ;
              req_valid_q <= 1'b1;
            end else begin
              state_q      <= ST_HOLD;
              inst_valid_q <= 1'b1;
              inst_q       <= imem_rsp_data;
              inst_pc_q    <= pc;
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid || inst_ready) begin
            state_q      <= ST_REQ;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
            if (!redirect_valid) cnt_q <= cnt_q + 64'd1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_22050612_fetch_unit.sv
// Scoreboard bench for the fetch unit: directed stimulus with a latency-programmable imem model.
module tb_ysyx_22050612_fetch_unit;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] cnt;
  } exp_inst_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int rsp_lat = 1;

  logic [63:0] exp_addr[$];
  exp_inst_t   exp_inst[$];

  ysyx_22050612_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h8000_0413;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // imem model: response rsp_lat cycles after each accepted request
  initial begin
    int          due;
    logic        hs;
    logic [63:0] hs_addr, r_addr;
    due = 0;
    r_addr = 64'd0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      hs      = !rst && imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (hs) begin
        due    = rsp_lat;
        r_addr = hs_addr;
      end
      if (due > 0) begin
        due--;
        if (due == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(r_addr);
        end
      end
    end
  end

  // Monitor: pops expectations on every request handshake and decode transfer
  always @(negedge clk) begin
    logic [63:0] a;
    exp_inst_t   e;
    if (!rst && imem_req_valid && imem_req_ready) begin
      if (exp_addr.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_req: got addr %h, expected no request", imem_req_addr);
      end else begin
        a = exp_addr.pop_front();
        chk("req_addr", imem_req_addr, a);
      end
    end
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_inst.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_fire: got inst %h pc %h, expected no transfer", inst, inst_pc);
      end else begin
        e = exp_inst.pop_front();
        chk("fire_inst", 64'(inst), 64'(e.inst));
        chk("fire_pc", inst_pc, e.pc);
        chk("fire_cnt", fetch_cnt, e.cnt);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    step();
    step();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'h8000_0000);
    chk("rst_fetch_cnt", fetch_cnt, 64'd0);

    // Basic loop: request at cycle 1, instruction at cycle 3
    exp_addr.push_back(64'h8000_0000);
    exp_inst.push_back('{32'h0000_0413, 64'h8000_0000, 64'd0});
    rst = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    chk("idle_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    chk("c1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c1_req_addr", imem_req_addr, 64'h8000_0000);
    step();
    imem_req_ready = 1'b0;
    step();
    chk("c3_inst_valid", 64'(inst_valid), 64'd1);
    step();
    chk("c4_next_addr", imem_req_addr, 64'h8000_0004);
    chk("c4_fetch_cnt", fetch_cnt, 64'd1);
    inst_ready = 1'b0;

    // Backpressure on request then on decode
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", 64'(imem_req_valid), 64'd1);
      chk("bp_req_addr", imem_req_addr, 64'h8000_0004);
      step();
    end
    exp_addr.push_back(64'h8000_0004);
    exp_inst.push_back('{32'h0000_0417, 64'h8000_0004, 64'd1});
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(inst_valid), 64'd1);
      chk("hold_inst", 64'(inst), 64'h0000_0417);
      chk("hold_pc", inst_pc, 64'h8000_0004);
      chk("hold_cnt", fetch_cnt, 64'd1);
      step();
    end
    inst_ready = 1'b1;
    step();
    chk("bp_cnt", fetch_cnt, 64'd2);
    chk("bp_next_addr", imem_req_addr, 64'h8000_0008);
    inst_ready = 1'b0;

    // Redirect in HOLD with decode ready: dropped, no count
    exp_addr.push_back(64'h8000_0008);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    chk("pre_redir_hold", 64'(inst_valid), 64'd1);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    chk("redir_hold_cnt", fetch_cnt, 64'd2);
    chk("redir_hold_addr", imem_req_addr, 64'h8000_0100);
    chk("redir_hold_valid", 64'(inst_valid), 64'd0);

    // Two redirects in WAIT, latest wins
    exp_addr.push_back(64'h8000_0100);
    rsp_lat = 3;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    redirect_pc    = 64'h8000_0300;
    step();
    redirect_valid = 1'b0;
    chk("wait_kill_valid", 64'(inst_valid), 64'd0);
    step();
    chk("wait_redir_addr", imem_req_addr, 64'h8000_0300);
    chk("wait_redir_req", 64'(imem_req_valid), 64'd1);
    chk("wait_redir_valid", 64'(inst_valid), 64'd0);

    // Redirect coincident with response
    exp_addr.push_back(64'h8000_0300);
    rsp_lat = 1;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    step();
    chk("coinc_rsp_addr", imem_req_addr, 64'h8000_0400);
    chk("coinc_rsp_valid", 64'(inst_valid), 64'd0);

    // Redirect coincident with request handshake
    exp_addr.push_back(64'h8000_0400);
    imem_req_ready = 1'b1;
    redirect_pc    = 64'h8000_0500;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    step();
    chk("coinc_hs_addr", imem_req_addr, 64'h8000_0500);
    chk("coinc_hs_valid", 64'(inst_valid), 64'd0);

    // Redirect in REQ before handshake: address held, response killed
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0600;
    step();
    redirect_valid = 1'b0;
    chk("req_addr_held", imem_req_addr, 64'h8000_0500);
    exp_addr.push_back(64'h8000_0500);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    chk("req_redir_addr", imem_req_addr, 64'h8000_0600);
    chk("req_redir_valid", 64'(inst_valid), 64'd0);

    // PC wrap; low redirect bits are masked
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    exp_addr.push_back(64'h8000_0600);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    chk("wrap_start_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_inst.push_back('{32'h7FFF_FBEF, 64'hFFFF_FFFF_FFFF_FFFC, 64'd2});
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    chk("wrap_hold", 64'(inst_valid), 64'd1);
    step();
    chk("wrap_addr", imem_req_addr, 64'd0);
    chk("wrap_cnt", fetch_cnt, 64'd3);

    // Reset during WAIT; late response must be ignored
    exp_addr.push_back(64'd0);
    rsp_lat = 3;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_mid_addr", imem_req_addr, 64'h8000_0000);
    chk("rst_mid_cnt", fetch_cnt, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rel_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rel_req_addr", imem_req_addr, 64'h8000_0000);
    step();
    chk("late_rsp_valid", 64'(inst_valid), 64'd0);
    chk("late_rsp_req", 64'(imem_req_valid), 64'd1);
    chk("late_rsp_addr", imem_req_addr, 64'h8000_0000);
    exp_addr.push_back(64'h8000_0000);
    exp_inst.push_back('{32'h0000_0413, 64'h8000_0000, 64'd0});
    rsp_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    step();
    chk("post_rst_cnt", fetch_cnt, 64'd1);
    chk("post_rst_addr", imem_req_addr, 64'h8000_0004);
    inst_ready = 1'b0;
    step();
    step();
    chk("addr_q_empty", 64'(exp_addr.size()), 64'd0);
    chk("inst_q_empty", 64'(exp_inst.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_fetch_unit.md
# ysyx_22050612_fetch_unit

Instruction fetch unit sitting directly upstream of decode/execute in the ysyx_22050612 core. It owns the architectural PC, issues one fetch at a time to instruction memory over a valid/ready request channel plus a response channel, and holds each fetched instruction until decode accepts it. It steps PC by 4 on each accepted instruction and takes redirects (`dnpc`) from the execute stage, squashing any in-flight wrong-path fetch.

## Interface
Parameters:
- `RESET_PC`, default 64'h8000_0000: first fetch address after reset.
- `INST_W`, default 32: instruction width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 64: fetch address, low 2 bits always 0.
- `imem_rsp_valid` in 1: response valid, one-cycle pulse, exactly one per accepted request.
- `imem_rsp_data` in INST_W: fetched instruction.
- `inst_valid` out 1: instruction held for decode.
- `inst_ready` in 1: decode accepts instruction.
- `inst` out INST_W: held instruction.
- `inst_pc` out 64: PC of held instruction.
- `redirect_valid` in 1: one-cycle pulse from execute, next PC is `redirect_pc`.
- `redirect_pc` in 64: redirect target; bits [1:0] forced to 0 internally.
- `fetch_cnt` out 64: count of instructions transferred to decode.

## Operation
- States: IDLE, REQ, WAIT, HOLD. `imem_req_valid = (state==REQ)`, `inst_valid = (state==HOLD)`.
- IDLE -> REQ unconditionally (first cycle after reset release).
- REQ: `imem_req_addr = pc`, stable while valid & !ready. On handshake -> WAIT.
- WAIT: on `imem_rsp_valid` -> capture data into `inst`, `pc` into `inst_pc`, go HOLD; if kill flag set, discard data, clear kill, load `pc <= pending`, go REQ.
- HOLD: transfer fires when `inst_valid & inst_ready & !redirect_valid`; on fire `pc <= pc+4` (64-bit, wraps modulo 2^64), `fetch_cnt++`, -> REQ.
- Redirect, per state:
  - HOLD: held instruction dropped (no fire, no count even if `inst_ready`=1), `pc <= redirect_pc`, -> REQ.
  - REQ before/at handshake: request address not changed; `pending <= redirect_pc`, kill flag set; on handshake -> WAIT with kill.
  - REQ with no handshake yet: same as above; kill applies to the response of that request.
  - WAIT: `pending <= redirect_pc`, kill set; if `imem_rsp_valid` same cycle, response discarded immediately and -> REQ with `pc <= redirect_pc`.
  - Repeated redirects while kill set: latest `redirect_pc` wins.
  - IDLE: `pc <= redirect_pc`.
- Decode must qualify acceptance with its own `redirect_valid`.

## Timing
- Reset values: state IDLE, `pc` = RESET_PC, `imem_req_valid` 0, `imem_req_addr` RESET_PC, `inst_valid` 0, `inst` 0, `inst_pc` RESET_PC, `fetch_cnt` 0, kill 0, `pending` 0.
- First request visible cycle 1 after `rst` falls.
- Best-case loop: REQ handshake cycle N, rsp at N+1, `inst_valid` at N+2, fire at N+2, next REQ at N+3: one instruction per 3 cycles.
- `inst`, `inst_pc` stable throughout HOLD.
- `rst` mid-fetch: all state cleared; an outstanding response arriving after reset release while in IDLE/REQ is ignored.

## Structure
- Shared package `ysyx_22050612_pkg`: fetch state enum, `RESET_PC` default, `INST_W`, PC step constant 4.
- One sub-module, `ysyx_22050612_fetch_pc`: pc, pending target and kill flag registers with next-PC select; FSM and output registers in the top.

## Test plan
- Reset release, `imem_req_ready`=1, rsp 1 cycle later with 32'h00000413, `inst_ready`=1 -> addr 8000_0000 at cycle 1, `inst_valid` cycle 3, next addr 8000_0004, `fetch_cnt`=1.
- Backpressure: `imem_req_ready` low 4 cycles then `inst_ready` low 5 cycles -> addr stable all 4 cycles, `inst`/`inst_pc` stable 5 cycles, single count.
- Redirect in HOLD with `inst_ready`=1, `redirect_pc`=8000_0103 -> no fire, `fetch_cnt` unchanged, next addr 8000_0100.
- Redirect in WAIT (target 8000_0200), then a second in WAIT (8000_0300), rsp arrives -> data discarded, `inst_valid` stays 0, next addr 8000_0300.
- Redirect coincident with rsp in WAIT, and coincident with req handshake -> response never reaches decode; next addr is redirect target.
- PC wrap: redirect to FFFF_FFFF_FFFF_FFFC, fire -> next addr 0; `rst` pulsed during WAIT -> addr RESET_PC after release, late rsp ignored.
